// File: rtl/logic_unit_test_ctrl.sv
// ---------------------------------------------------------------------------
// logic_unit_test_ctrl
//
// Built-in self-test sequencer for an external 2-input bitwise logic unit.
// It walks every (op, a, b) combination, holds each vector for LAT+1 cycles,
// samples the unit's result on the last edge of the hold window, checks it
// against an internal golden model and counts mismatches. The first failing
// vector is captured for diagnosis.
//
// Ports:
//   clk, rst           clock (rising edge) and asynchronous active-high reset
//   start              begin a sweep (honoured only in IDLE)
//   abort              terminate a running sweep
//   dut_a/dut_b/dut_op vector driven to the logic unit (op: AND/OR/XOR/NAND)
//   dut_res            result returned by the logic unit
//   busy               sweep in progress
//   done               one-cycle pulse on normal completion
//   pass               last completed sweep had zero mismatches
//   err_count          mismatching vectors in the current or last sweep
//   fail_valid         first-failure record is valid
//   fail_op/a/b/res    first failing vector and its observed result
// ---------------------------------------------------------------------------
module logic_unit_test_ctrl #(
    parameter int WIDTH = 4,
    parameter int LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    output logic [1:0]           dut_op,
    input  logic [WIDTH-1:0]     dut_res,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+2:0]   err_count,
    output logic                 fail_valid,
    output logic [1:0]           fail_op,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic [WIDTH-1:0]     fail_res
);

    // Vector register is {op, a, b} so a single increment walks op outermost,
    // b innermost. The all-ones value is the final vector (op=3, a=b=max).
    localparam int VW = 2*WIDTH + 2;
    localparam int EW = 2*WIDTH + 3;

    localparam logic [2:0]    HOLD_LAST = 3'(LAT);
    localparam logic [VW-1:0] VEC_LAST  = {VW{1'b1}};
    localparam logic [VW-1:0] VEC_ONE   = {{(VW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0] ERR_ONE   = {{(EW-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [VW-1:0]    vec_q, vec_d;
    logic [2:0]       hold_q, hold_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [EW-1:0]    err_q, err_d;
    logic             fv_q, fv_d;
    logic [1:0]       fop_q, fop_d;
    logic [WIDTH-1:0] fa_q, fa_d;
    logic [WIDTH-1:0] fb_q, fb_d;
    logic [WIDTH-1:0] fres_q, fres_d;

    logic [1:0]       cur_op_s;
    logic [WIDTH-1:0] cur_a_s;
    logic [WIDTH-1:0] cur_b_s;
    logic [WIDTH-1:0] golden_s;
    logic             mismatch_s;
    logic             sample_s;
    logic [EW-1:0]    err_next_s;

    // Reference behaviour of the logic unit, already WIDTH bits wide.
    function automatic logic [WIDTH-1:0] golden_fn(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = a ^ b;
            2'd3:    r = ~(a & b);
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    assign cur_op_s   = vec_q[VW-1:VW-2];
    assign cur_a_s    = vec_q[2*WIDTH-1:WIDTH];
    assign cur_b_s    = vec_q[WIDTH-1:0];
    assign golden_s   = golden_fn(cur_op_s, cur_a_s, cur_b_s);
    assign mismatch_s = (dut_res != golden_s);
    assign sample_s   = (hold_q == HOLD_LAST);
    assign err_next_s = mismatch_s ? (err_q + ERR_ONE) : err_q;

    // Next-state logic for the sweep sequencer and result bookkeeping.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fop_d   = fop_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        fres_d  = fres_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    vec_d   = {VW{1'b0}};
                    hold_d  = 3'd0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = {EW{1'b0}};
                    fv_d    = 1'b0;
                    fop_d   = 2'd0;
                    fa_d    = {WIDTH{1'b0}};
                    fb_d    = {WIDTH{1'b0}};
                    fres_d  = {WIDTH{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Abort wins over a vector completing on the same edge;
                // partial err_count and fail record are kept.
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                end else if (sample_s) begin
                    hold_d = 3'd0;
                    err_d  = err_next_s;
                    if (mismatch_s && !fv_q) begin
                        fv_d   = 1'b1;
                        fop_d  = cur_op_s;
                        fa_d   = cur_a_s;
                        fb_d   = cur_b_s;
                        fres_d = dut_res;
                    end else begin
                        fv_d = fv_q;
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_next_s == {EW{1'b0}});
                    end else begin
                        vec_d = vec_q + VEC_ONE;
                    end
                end else begin
                    hold_d = hold_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= {VW{1'b0}};
            hold_q  <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= {EW{1'b0}};
            fv_q    <= 1'b0;
            fop_q   <= 2'd0;
            fa_q    <= {WIDTH{1'b0}};
            fb_q    <= {WIDTH{1'b0}};
            fres_q  <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fop_q   <= fop_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            fres_q  <= fres_d;
        end
    end

    assign dut_op     = cur_op_s;
    assign dut_a      = cur_a_s;
    assign dut_b      = cur_b_s;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_op    = fop_q;
    assign fail_a     = fa_q;
    assign fail_b     = fb_q;
    assign fail_res   = fres_q;

endmodule

// File: tb/tb_logic_unit_test_ctrl.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_test_ctrl
//
// Three controller instances: A (WIDTH=2, LAT=1) with an optional bit0-stuck
// fault, B (WIDTH=1, LAT=0) purely combinational, C (WIDTH=2, LAT=3) with a
// selectable model delay. Expected sweep results are pushed to a queue when
// start is driven and popped when done is seen.
// ---------------------------------------------------------------------------
module tb_logic_unit_test_ctrl;

    logic clk;
    logic rst;
    logic [2:0] start_v;
    logic [2:0] abort_v;
    logic fault_a;
    int   dly_c;

    int n_chk;
    int n_err;

    typedef struct {
        logic [31:0] err;
        logic [31:0] pass;
        logic [31:0] fv;
        logic [31:0] fop;
        logic [31:0] fa;
        logic [31:0] fb;
        logic [31:0] fres;
        int          cycles;
        bit          err_nonzero;
    } exp_t;

    exp_t exp_q[$];

    // Instance A
    logic [1:0] a_a, a_b, a_op, a_res, a_fop, a_fa, a_fb, a_fres;
    logic       a_busy, a_done, a_pass, a_fv;
    logic [6:0] a_err;
    // Instance B
    logic [0:0] b_a, b_b, b_res, b_fa, b_fb, b_fres;
    logic [1:0] b_op, b_fop;
    logic       b_busy, b_done, b_pass, b_fv;
    logic [4:0] b_err;
    // Instance C
    logic [1:0] c_a, c_b, c_op, c_res, c_fop, c_fa, c_fb, c_fres;
    logic       c_busy, c_done, c_pass, c_fv;
    logic [6:0] c_err;

    logic [31:0] o_err[3], o_fa[3], o_fb[3], o_fres[3], o_vec[3], o_fop[3];
    logic        o_busy[3], o_done[3], o_pass[3], o_fv[3];

    always #5 clk = ~clk;

    logic_unit_test_ctrl #(.WIDTH(2), .LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .dut_a(a_a), .dut_b(a_b), .dut_op(a_op), .dut_res(a_res),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
        .fail_valid(a_fv), .fail_op(a_fop), .fail_a(a_fa), .fail_b(a_fb),
        .fail_res(a_fres));

    logic_unit_test_ctrl #(.WIDTH(1), .LAT(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .dut_a(b_a), .dut_b(b_b), .dut_op(b_op), .dut_res(b_res),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
        .fail_valid(b_fv), .fail_op(b_fop), .fail_a(b_fa), .fail_b(b_fb),
        .fail_res(b_fres));

    logic_unit_test_ctrl #(.WIDTH(2), .LAT(3)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]),
        .dut_a(c_a), .dut_b(c_b), .dut_op(c_op), .dut_res(c_res),
        .busy(c_busy), .done(c_done), .pass(c_pass), .err_count(c_err),
        .fail_valid(c_fv), .fail_op(c_fop), .fail_a(c_fa), .fail_b(c_fb),
        .fail_res(c_fres));

    assign o_err[0] = 32'(a_err);  assign o_err[1] = 32'(b_err);  assign o_err[2] = 32'(c_err);
    assign o_fa[0]  = 32'(a_fa);   assign o_fa[1]  = 32'(b_fa);   assign o_fa[2]  = 32'(c_fa);
    assign o_fb[0]  = 32'(a_fb);   assign o_fb[1]  = 32'(b_fb);   assign o_fb[2]  = 32'(c_fb);
    assign o_fres[0] = 32'(a_fres); assign o_fres[1] = 32'(b_fres); assign o_fres[2] = 32'(c_fres);
    assign o_fop[0] = 32'(a_fop);  assign o_fop[1] = 32'(b_fop);  assign o_fop[2] = 32'(c_fop);
    assign o_vec[0] = 32'({a_op, a_a, a_b});
    assign o_vec[1] = 32'({b_op, b_a, b_b});
    assign o_vec[2] = 32'({c_op, c_a, c_b});
    assign o_busy[0] = a_busy; assign o_busy[1] = b_busy; assign o_busy[2] = c_busy;
    assign o_done[0] = a_done; assign o_done[1] = b_done; assign o_done[2] = c_done;
    assign o_pass[0] = a_pass; assign o_pass[1] = b_pass; assign o_pass[2] = c_pass;
    assign o_fv[0]   = a_fv;   assign o_fv[1]   = b_fv;   assign o_fv[2]   = c_fv;

    function automatic logic [31:0] ref_logic(input int w, input logic [31:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mask;
        logic [31:0] r;
        mask = (32'd1 << w) - 32'd1;
        case (op[1:0])
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = a ^ b;
            default: r = ~(a & b);
        endcase
        return r & mask;
    endfunction

    // Logic unit models: A has one register stage, B is combinational,
    // C is a tapped delay line whose tap is chosen by dly_c.
    logic [1:0] pa;
    logic [1:0] pc[0:7];

    always @(posedge clk) pa <= 2'(ref_logic(2, 32'(a_op), 32'(a_a), 32'(a_b)));
    assign a_res = fault_a ? (pa & 2'b10) : pa;

    assign b_res = 1'(ref_logic(1, 32'(b_op), 32'(b_a), 32'(b_b)));

    always @(posedge clk) begin
        pc[0] <= 2'(ref_logic(2, 32'(c_op), 32'(c_a), 32'(c_b)));
        for (int i = 1; i < 8; i++) pc[i] <= pc[i-1];
    end
    assign c_res = pc[dly_c-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected outcome of a full sweep against a model that is either
    // correct or has result bit0 stuck at 0.
    function automatic exp_t predict(input int w, input int l, input bit stuck);
        exp_t e;
        logic [31:0] g, obs;
        e.err = 0; e.pass = 0; e.fv = 0; e.fop = 0; e.fa = 0; e.fb = 0; e.fres = 0;
        e.err_nonzero = 1'b0;
        for (int op = 0; op < 4; op++)
            for (int a = 0; a < (1 << w); a++)
                for (int b = 0; b < (1 << w); b++) begin
                    g   = ref_logic(w, 32'(op), 32'(a), 32'(b));
                    obs = stuck ? (g & ~32'd1) : g;
                    if (obs != g) begin
                        e.err = e.err + 32'd1;
                        if (e.fv == 32'd0) begin
                            e.fv = 32'd1; e.fop = 32'(op); e.fa = 32'(a);
                            e.fb = 32'(b); e.fres = obs;
                        end
                    end
                end
        e.pass   = (e.err == 32'd0) ? 32'd1 : 32'd0;
        e.cycles = 4 * (1 << (2*w)) * (l + 1);
        return e;
    endfunction

    task automatic sweep(input int k, input exp_t e);
        int cyc;
        bit seen;
        exp_t ex;
        exp_q.push_back(e);
        @(negedge clk); start_v[k] = 1'b1;
        @(negedge clk); start_v[k] = 1'b0;
        check("clr_err", o_err[k], 32'd0);
        check("clr_fv", 32'(o_fv[k]), 32'd0);
        cyc = 0; seen = 1'b0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            if (o_done[k]) seen = 1'b1;
            else begin
                if (o_busy[k]) cyc++;
                @(negedge clk);
            end
        end
        ex = exp_q.pop_front();
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("cycles", 32'(cyc), 32'(ex.cycles));
            check("busy_in_done", 32'(o_busy[k]), 32'd0);
            check("pass", 32'(o_pass[k]), ex.pass);
            if (ex.err_nonzero) begin
                check("err_nonzero", 32'(o_err[k] != 32'd0), 32'd1);
            end else begin
                check("err_count", o_err[k], ex.err);
                check("fail_valid", 32'(o_fv[k]), ex.fv);
                if (ex.fv != 32'd0) begin
                    check("fail_op", o_fop[k], ex.fop);
                    check("fail_a", o_fa[k], ex.fa);
                    check("fail_b", o_fb[k], ex.fb);
                    check("fail_res", o_fres[k], ex.fres);
                end
            end
            @(negedge clk);
            check("done_one_cycle", 32'(o_done[k]), 32'd0);
            check("pass_hold", 32'(o_pass[k]), ex.pass);
        end
    endtask

    initial begin
        exp_t e;
        bit done_seen;
        clk = 1'b0; rst = 1'b1; start_v = 3'b000; abort_v = 3'b000;
        fault_a = 1'b0; dly_c = 3;
        n_chk = 0; n_err = 0;

        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_busy", 32'(o_busy[k]), 32'd0);
            check("rst_done", 32'(o_done[k]), 32'd0);
            check("rst_pass", 32'(o_pass[k]), 32'd0);
            check("rst_err", o_err[k], 32'd0);
            check("rst_vec", o_vec[k], 32'd0);
        end
        rst = 1'b0;

        // Correct unit, then bit0 stuck at 0.
        sweep(0, predict(2, 1, 1'b0));
        fault_a = 1'b1;
        sweep(0, predict(2, 1, 1'b1));
        fault_a = 1'b0;

        // Combinational unit, WIDTH=1.
        sweep(1, predict(1, 0, 1'b0));

        // Wrong model latency, then corrected.
        dly_c = 4;
        e = predict(2, 3, 1'b0);
        e.err_nonzero = 1'b1;
        e.pass = 32'd0;
        sweep(2, e);
        dly_c = 3;
        sweep(2, predict(2, 3, 1'b0));

        // Abort 20 cycles in, with an ignored start at cycle 10.
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            check("abort_vec", o_vec[0], 32'((n - 1) / 2));
            check("abort_busy", 32'(o_busy[0]), 32'd1);
            start_v[0] = (n == 10);
            if (n == 20) abort_v[0] = 1'b1;
            if (n != 20) @(negedge clk);
        end
        @(negedge clk); abort_v[0] = 1'b0;
        check("abort_idle_busy", 32'(o_busy[0]), 32'd0);
        check("abort_pass", 32'(o_pass[0]), 32'd0);
        check("abort_vec_hold", o_vec[0], 32'd9);
        check("abort_err_keep", o_err[0], 32'd0);
        done_seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            done_seen |= o_done[0];
            @(negedge clk);
        end
        check("abort_no_done", 32'(done_seen), 32'd0);

        // Asynchronous reset mid-sweep, then a clean full sweep.
        fault_a = 1'b1;
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(o_busy[0]), 32'd0);
        check("arst_err", o_err[0], 32'd0);
        check("arst_fv", 32'(o_fv[0]), 32'd0);
        check("arst_vec", o_vec[0], 32'd0);
        check("arst_pass", 32'(o_pass[0]), 32'd0);
        @(negedge clk); rst = 1'b0;
        fault_a = 1'b0;
        sweep(0, predict(2, 1, 1'b0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
